// File: rtl/inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq : iterative AES-128 InvSubBytes engine.
//
// Takes a 128-bit state over a valid/ready handshake, replaces LANES bytes per
// clock with their inverse S-box values (MSB byte first) and returns the
// result over a second valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data holds a state to transform
//   in_ready   engine can accept a state (IDLE only)
//   in_data    input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  out_data holds a completed result
//   out_ready  consumer accepts out_data
//   out_data   InvSubBytes(in_data), same byte ordering
//   busy       high while the engine is in RUN or DONE
//
// inv_s_box : FIPS-197 inverse S-box lookup, a (in) -> c (out).
// ---------------------------------------------------------------------------

module inv_s_box (
    input  logic [7:0] a,
    output logic [7:0] c
);
    // Row r of the table holds entries 16*r .. 16*r+15; entry 0 sits at the MSB.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] bit_ofs_s;

    // Table lookup: entry a lives at bits [2047-8a -: 8].
    always_comb begin
        bit_ofs_s = {a, 3'b000};
        c         = INV_SBOX_TBL[11'd2047 - bit_ofs_s -: 8];
    end
endmodule

module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    work_q, work_d;
    logic [127:0]    out_data_q, out_data_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [3:0]      byte_idx_s [LANES];
    logic [7:0]      lane_in_s  [LANES];
    logic [7:0]      lane_out_s [LANES];

    // Byte positions handled this cycle depend on cnt only.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            byte_idx_s[l] = 4'(int'(cnt_q) * LANES + l);
            lane_in_s[l]  = work_q[7'd127 - {byte_idx_s[l], 3'b000} -: 8];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            inv_s_box u_inv_s_box (
                .a (lane_in_s[g]),
                .c (lane_out_s[g])
            );
        end
    endgenerate

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                // in_ready_q is low in the first cycle after reset, so gate on it
                // to keep acceptance consistent with what upstream observes.
                if (in_valid && in_ready_q) begin
                    work_d  = in_data;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[7'd127 - {byte_idx_s[l], 3'b000} -: 8] = lane_out_s[l];
                end
                if (cnt_q == CW'(NCYC - 1)) begin
                    state_d    = ST_DONE;
                    out_data_d = work_d;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            work_q      <= 128'd0;
            out_data_q  <= 128'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
endmodule
